store_rmw_unit: RTL

Store-path companion to the load formatter in the datapath's memory stage. Accepts S-type stores (sb, sh, sw, sd) from the control unit and performs them on the 64-bit-word data memory, which has no byte enables. sd is written directly. Narrow stores use a read-modify-write sequence that merges rs2 bytes into the addressed word. The block also detects misaligned addresses and illegal funct3 values, and signals completion with a single-cycle pulse.

---
 rtl/store_rmw_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/store_rmw_unit.sv
// rtl/store_rmw_unit.sv - sb/sh/sw/sd store unit with read-modify-write on a byte-enable-free 64-bit memory
module store_rmw_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [2:0]  r_state;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [1:0]  r_f3;
  logic        r_err;
  logic [63:0] r_word;

  logic        w_accept;
  logic [2:0]  w_f3;
  logic [2:0]  w_off;
  logic        w_err;
  logic [7:0]  w_lanes;
  logic [7:0]  w_be;
  logic [63:0] w_bitmask;
  logic [63:0] w_shifted;
  logic [63:0] w_merged;

  assign w_f3     = inst[14:12];
  assign w_off    = addr[2:0];
  assign w_accept = start && (r_state == S_IDLE) && (inst[6:0] == OP_STORE);

  always_comb begin
    w_err = 1'b0;
    if (w_f3[2]) begin
      w_err = 1'b1;
    end else begin
      case (w_f3[1:0])
        2'b01:   w_err = w_off[0];
        2'b10:   w_err = |w_off[1:0];
        2'b11:   w_err = |w_off;
        default: w_err = 1'b0;
      endcase
    end
  end

  // Accepted narrow stores are aligned, so the shifted lane mask never wraps.
  always_comb begin
    case (r_f3)
      2'b00:   w_lanes = 8'h01;
      2'b01:   w_lanes = 8'h03;
      default: w_lanes = 8'h0F;
    endcase
    w_be      = w_lanes << r_addr[2:0];
    w_bitmask = '0;
    for (int k = 0; k < 8; k++) begin
      w_bitmask[8*k +: 8] = {8{w_be[k]}};
    end
    w_shifted = r_wdata << {r_addr[2:0], 3'b000};
    w_merged  = (mem_rdata & ~w_bitmask) | (w_shifted & w_bitmask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_err   <= 1'b0;
      r_word  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_f3    <= w_f3[1:0];
            r_err   <= w_err;
            if (w_err) begin
              r_state <= S_DONE;
            end else if (w_f3[1:0] == 2'b11) begin
              r_word  <= wdata;
              r_state <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ:  r_state <= S_WAIT;
        S_WAIT: begin
          r_word  <= w_merged;
          r_state <= S_WRITE;
        end
        S_WRITE: r_state <= S_DONE;
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr  = {r_addr[63:3], 3'b000};
  assign mem_rd    = (r_state == S_READ);
  assign mem_wr    = (r_state == S_WRITE);
  assign mem_wdata = r_word;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_DONE) && r_err;

endmodule
